// File: rtl/io_map_pkg.sv
// -----------------------------------------------------------------------------
// io_map_pkg
// Shared definitions for the IO output register bank write path.
//   DATA_W          : width of CPU / master address and data buses
//   IO_OUTn_ADDR    : byte addresses of the three output registers
//   io_wr_t         : one posted write {addr, data}
//   gnt_src_e       : which source owns the write port in a given cycle
//   io_addr_ok()    : 1 when an address decodes to one of the output registers
// -----------------------------------------------------------------------------
package io_map_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] IO_OUT0_ADDR = 32'h0000_0080;
  localparam logic [DATA_W-1:0] IO_OUT1_ADDR = 32'h0000_0084;
  localparam logic [DATA_W-1:0] IO_OUT2_ADDR = 32'h0000_0088;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } io_wr_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_MST  = 2'd2
  } gnt_src_e;

  // Only the word index addr[7:2] is decoded; the bank ignores the upper bits
  // and the byte offset.
  function automatic logic io_addr_ok(input logic [DATA_W-1:0] addr);
    return (addr[7:2] == IO_OUT0_ADDR[7:2]) ||
           (addr[7:2] == IO_OUT1_ADDR[7:2]) ||
           (addr[7:2] == IO_OUT2_ADDR[7:2]);
  endfunction

endpackage

// File: rtl/io_post_fifo.sv
// -----------------------------------------------------------------------------
// io_post_fifo
// Small synchronous FIFO holding posted CPU writes. A push while full is only
// accepted when a pop happens in the same cycle (the slot frees at that edge).
// Ports:
//   io_clk     clock
//   clr        synchronous active-high reset; empties the FIFO
//   push       write push_data at the tail
//   push_data  entry to store
//   pop        remove the head entry
//   full       DEPTH entries stored
//   empty      no entries stored
//   head       oldest entry (valid only when !empty)
// -----------------------------------------------------------------------------
module io_post_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         io_clk,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block so that no path leaves it unassigned and infers a latch.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge.
  always_ff @(posedge io_clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are live, so clearing the data would only cost reset routing.
  always_ff @(posedge io_clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/io_write_arbiter.sv
// -----------------------------------------------------------------------------
// io_write_arbiter
// Shares the write port of the IO output register bank (80h/84h/88h) between
// the CPU store path and NM valid/ready masters. CPU stores are posted into a
// FIFO because the CPU never stalls. One request is granted per cycle and
// registered onto wr_en/wr_addr/wr_data at the next edge.
// Ports:
//   io_clk    clock
//   clr       synchronous active-high reset
//   cpu_we    CPU store pulse (never stalled)
//   cpu_addr  CPU store address
//   cpu_data  CPU store data
//   m_valid   per-master request
//   m_addr    per-master address, slice [32i+31:32i]
//   m_data    per-master data, slice [32i+31:32i]
//   m_ready   per-master accept this cycle (combinational)
//   wr_en     registered write strobe to the register bank
//   wr_addr   registered write address
//   wr_data   registered write data
//   bad_addr  registered pulse: the consumed request decoded to no register
//   cpu_ovf   sticky: a CPU store was dropped because the FIFO was full
//   busy      FIFO non-empty or any master requesting
// -----------------------------------------------------------------------------
module io_write_arbiter
  import io_map_pkg::*;
#(
  parameter int NM             = 2,
  parameter int CPU_FIFO_DEPTH = 2,
  parameter int MAX_CPU_BURST  = 2
) (
  input  logic                 io_clk,
  input  logic                 clr,
  input  logic                 cpu_we,
  input  logic [DATA_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_data,
  input  logic [NM-1:0]        m_valid,
  input  logic [NM*DATA_W-1:0] m_addr,
  input  logic [NM*DATA_W-1:0] m_data,
  output logic [NM-1:0]        m_ready,
  output logic                 wr_en,
  output logic [DATA_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 bad_addr,
  output logic                 cpu_ovf,
  output logic                 busy
);

  localparam int RR_W = (NM > 1) ? $clog2(NM) : 1;
  localparam int BC_W = (MAX_CPU_BURST > 0) ? $clog2(MAX_CPU_BURST + 1) : 1;

  // ---------------------------------------------------------------------------
  // Posted CPU write FIFO
  // ---------------------------------------------------------------------------
  io_wr_t   fifo_head;
  io_wr_t   fifo_in;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;
  logic     any_valid;
  gnt_src_e gnt_src;

  assign fifo_in   = '{addr: cpu_addr, data: cpu_data};
  assign any_valid = |m_valid;
  assign fifo_pop  = (gnt_src == GNT_CPU);
  // A store into a full FIFO still fits if the head leaves in the same cycle.
  assign fifo_push = cpu_we && !clr && (!fifo_full || fifo_pop);
  assign busy      = !fifo_empty || any_valid;

  io_post_fifo #(
    .DEPTH (CPU_FIFO_DEPTH),
    .W     (2 * DATA_W)
  ) u_fifo (
    .io_clk    (io_clk),
    .clr       (clr),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // ---------------------------------------------------------------------------
  // Arbitration: CPU first unless it has used its burst allowance while a
  // master waits; otherwise round-robin among masters starting at rr_ptr.
  // ---------------------------------------------------------------------------
  logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  int                mst_idx;
  logic              found;

  always_comb begin
    gnt_src  = GNT_NONE;
    m_ready  = '0;
    rr_ptr_d = rr_ptr_q;
    gnt_addr = '0;
    gnt_data = '0;
    mst_idx  = 0;
    found    = 1'b0;
    if (!clr) begin
      if (!fifo_empty &&
          (!any_valid || burst_cnt_q < BC_W'(MAX_CPU_BURST))) begin
        gnt_src  = GNT_CPU;
        gnt_addr = fifo_head.addr;
        gnt_data = fifo_head.data;
      end else if (any_valid) begin
        for (int k = 0; k < NM; k++) begin
          if (!found && m_valid[(int'(rr_ptr_q) + k) % NM]) begin
            found   = 1'b1;
            mst_idx = (int'(rr_ptr_q) + k) % NM;
          end
        end
        gnt_src          = GNT_MST;
        m_ready[mst_idx] = 1'b1;
        gnt_addr         = m_addr[mst_idx*DATA_W +: DATA_W];
        gnt_data         = m_data[mst_idx*DATA_W +: DATA_W];
        rr_ptr_d         = (mst_idx == NM - 1) ? '0 : RR_W'(mst_idx + 1);
      end
    end
  end

  // Counts CPU grants taken while a master is kept waiting; any master grant
  // or an idle master side restarts the allowance.
  always_comb begin
    burst_cnt_d = '0;
    if (gnt_src == GNT_CPU && any_valid) begin
      burst_cnt_d = (burst_cnt_q == BC_W'(MAX_CPU_BURST)) ? burst_cnt_q
                                                          : burst_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              bad_addr_q, bad_addr_d;
  logic              cpu_ovf_q, cpu_ovf_d;
  logic              gnt_any;
  logic              gnt_ok;

  always_comb begin
    gnt_any    = (gnt_src != GNT_NONE);
    gnt_ok     = io_addr_ok(gnt_addr);
    wr_en_d    = gnt_any && gnt_ok;
    bad_addr_d = gnt_any && !gnt_ok;
    wr_addr_d  = gnt_any ? gnt_addr : wr_addr_q;
    wr_data_d  = gnt_any ? gnt_data : wr_data_q;
    cpu_ovf_d  = cpu_ovf_q || (cpu_we && fifo_full && !fifo_pop);
  end

  always_ff @(posedge io_clk) begin
    if (clr) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      bad_addr_q  <= 1'b0;
      cpu_ovf_q   <= 1'b0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      bad_addr_q  <= bad_addr_d;
      cpu_ovf_q   <= cpu_ovf_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign bad_addr = bad_addr_q;
  assign cpu_ovf  = cpu_ovf_q;

endmodule
